// File: rtl/cpu_pkg.sv
// Definitions shared by the register file, its clear sequencer and the hazard unit.
package cpu_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;
   localparam int unsigned REG_ZERO     = 0;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } rf_state_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: sweeps zeros through registers 1..NUM_REGS-1 after reset or on request,
// and arbitrates the single array write port between the sweep and architectural writes.
module regfile_clear_seq
   import cpu_pkg::*;
#(
   parameter int unsigned XLEN     = XLEN_DEFAULT,
   parameter int unsigned NUM_REGS = 32,
   localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_req_i,
   input  logic              write_enable_i,
   input  logic [ADDR_W-1:0] write_reg_i,
   input  logic [XLEN-1:0]   write_data_i,
   output rf_state_e         state_o,
   output logic              clear_busy_o,
   output logic              write_drop_o,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_idx_o,
   output logic [XLEN-1:0]   wr_data_o
);

   localparam logic [ADDR_W-1:0] IDX_ZERO  = ADDR_W'(REG_ZERO);
   localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(NUM_REGS - 1);

   rf_state_e         state_q;
   logic [ADDR_W-1:0] idx_q;
   logic              busy_q;
   logic              drop_q;

   // Sweep FSM with registered busy and drop flags; reset enters the sweep directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SWEEP;
         idx_q   <= IDX_FIRST;
         busy_q  <= 1'b1;
         drop_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               drop_q <= 1'b0;
               if (clear_req_i) begin
                  state_q <= SWEEP;
                  idx_q   <= IDX_FIRST;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            SWEEP: begin
               drop_q <= write_enable_i && (write_reg_i != IDX_ZERO);
               if (idx_q == IDX_LAST) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  idx_q <= idx_q + IDX_FIRST;
               end
            end
            default: begin
               state_q <= SWEEP;
               idx_q   <= IDX_FIRST;
               busy_q  <= 1'b1;
               drop_q  <= 1'b0;
            end
         endcase
      end
   end

   // Array write port mux: the sweep owns the port while it runs, and index 0 is never stored.
   always_comb begin
      wr_en_o   = 1'b0;
      wr_idx_o  = IDX_ZERO;
      wr_data_o = {XLEN{1'b0}};
      if (state_q == SWEEP) begin
         wr_en_o  = 1'b1;
         wr_idx_o = idx_q;
      end else begin
         wr_en_o   = write_enable_i && (write_reg_i != IDX_ZERO);
         wr_idx_o  = write_reg_i;
         wr_data_o = write_data_i;
      end
   end

   assign state_o      = state_q;
   assign clear_busy_o = busy_q;
   assign write_drop_o = drop_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised integer register file: combinational reads with write-through bypass,
// hardware clear sweep with busy handshake, and a registered tap of one register.
module regfile_param
   import cpu_pkg::*;
#(
   parameter int unsigned XLEN     = XLEN_DEFAULT,
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned TAP_REG  = 5,
   localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic              write_enable,
   input  logic [XLEN-1:0]   write_data,
   input  logic              clear_req,
   output logic [XLEN-1:0]   read_data1,
   output logic [XLEN-1:0]   read_data2,
   output logic [XLEN-1:0]   tap_data,
   output logic              clear_busy,
   output logic              write_drop
);

   localparam logic [ADDR_W-1:0] IDX_ZERO = ADDR_W'(REG_ZERO);
   localparam logic [ADDR_W-1:0] IDX_TAP  = ADDR_W'(TAP_REG);

   rf_state_e         state_s;
   logic              wr_en_s;
   logic [ADDR_W-1:0] wr_idx_s;
   logic [XLEN-1:0]   wr_data_s;
   logic              bypass_en_s;
   logic [XLEN-1:0]   rd1_s;
   logic [XLEN-1:0]   rd2_s;
   logic [XLEN-1:0]   tap_d;
   logic [XLEN-1:0]   tap_q;

   // No reset on the array so it maps onto distributed RAM; the sweep clears it instead.
   logic [XLEN-1:0]   regs_q [NUM_REGS];

   regfile_clear_seq #(
      .XLEN     (XLEN),
      .NUM_REGS (NUM_REGS)
   ) u_clear_seq (
      .clk            (clk),
      .rst_n          (rst_n),
      .clear_req_i    (clear_req),
      .write_enable_i (write_enable),
      .write_reg_i    (write_reg),
      .write_data_i   (write_data),
      .state_o        (state_s),
      .clear_busy_o   (clear_busy),
      .write_drop_o   (write_drop),
      .wr_en_o        (wr_en_s),
      .wr_idx_o       (wr_idx_s),
      .wr_data_o      (wr_data_s)
   );

   // Array write from the sequencer-selected source.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         regs_q[wr_idx_s] <= wr_data_s;
      end
   end

   assign bypass_en_s = (state_s == IDLE) && write_enable && (write_reg != IDX_ZERO);

   // Read ports: zero register and sweep read 0, otherwise bypass or stored value.
   always_comb begin
      rd1_s = {XLEN{1'b0}};
      rd2_s = {XLEN{1'b0}};
      if (state_s == SWEEP || read_reg1 == IDX_ZERO) begin
         rd1_s = {XLEN{1'b0}};
      end else if (bypass_en_s && read_reg1 == write_reg) begin
         rd1_s = write_data;
      end else begin
         rd1_s = regs_q[read_reg1];
      end
      if (state_s == SWEEP || read_reg2 == IDX_ZERO) begin
         rd2_s = {XLEN{1'b0}};
      end else if (bypass_en_s && read_reg2 == write_reg) begin
         rd2_s = write_data;
      end else begin
         rd2_s = regs_q[read_reg2];
      end
   end

   // Tap next value is what the tapped register will hold after this edge.
   always_comb begin
      tap_d = {XLEN{1'b0}};
      if (IDX_TAP == IDX_ZERO) begin
         tap_d = {XLEN{1'b0}};
      end else if (wr_en_s && wr_idx_s == IDX_TAP) begin
         tap_d = wr_data_s;
      end else begin
         tap_d = regs_q[IDX_TAP];
      end
   end

   // Registered tap output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap_q <= {XLEN{1'b0}};
      end else begin
         tap_q <= tap_d;
      end
   end

   assign read_data1 = rd1_s;
   assign read_data2 = rd2_s;
   assign tap_data   = tap_q;

endmodule

// File: tb/tb_regfile_param.sv
// Randomised self-checking bench for regfile_param against a behavioural array model.
module tb_regfile_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // 32 x 32 instance
   logic        rst_n;
   logic [4:0]  rr1, rr2, wr;
   logic        we, creq;
   logic [31:0] wd;
   logic [31:0] rd1, rd2, tap;
   logic        busy, drop;
   logic [31:0] model [32];

   // 16 x 64 instance
   logic        rst64_n;
   logic [3:0]  rr1_64, rr2_64, wr_64;
   logic        we_64, creq_64;
   logic [63:0] wd_64;
   logic [63:0] rd1_64, rd2_64, tap_64;
   logic        busy_64, drop_64;

   regfile_param dut (
      .clk(clk), .rst_n(rst_n), .read_reg1(rr1), .read_reg2(rr2), .write_reg(wr),
      .write_enable(we), .write_data(wd), .clear_req(creq), .read_data1(rd1),
      .read_data2(rd2), .tap_data(tap), .clear_busy(busy), .write_drop(drop)
   );

   regfile_param #(.XLEN(64), .NUM_REGS(16), .TAP_REG(5)) dut64 (
      .clk(clk), .rst_n(rst64_n), .read_reg1(rr1_64), .read_reg2(rr2_64), .write_reg(wr_64),
      .write_enable(we_64), .write_data(wd_64), .clear_req(creq_64), .read_data1(rd1_64),
      .read_data2(rd2_64), .tap_data(tap_64), .clear_busy(busy_64), .write_drop(drop_64)
   );

   function automatic logic [31:0] exp_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (we && wr != 5'd0 && idx == wr) return wd;
      return model[idx];
   endfunction

   task automatic count_sweep(input string name, input int expected);
      int cnt = 0;
      while (busy === 1'b1 && cnt < 200) begin
         checks++;
         if (rd1 !== 32'd0) begin
            errors++;
            $display("FAIL %s_read_during_sweep: got %h expected 0", name, rd1);
         end
         cnt++;
         @(negedge clk);
      end
      checks++;
      if (cnt != expected) begin
         errors++;
         $display("FAIL %s_busy_cycles: got %0d expected %0d", name, cnt, expected);
      end
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
   endtask

   task automatic check_all_zero(input string name);
      for (int i = 0; i < 32; i++) begin
         rr1 = 5'(i);
         rr2 = 5'(31 - i);
         #1;
         checks++;
         if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
            errors++;
            $display("FAIL %s_zero r%0d: got %h/%h expected 0", name, i, rd1, rd2);
         end
      end
   endtask

   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      we = 1'b1; wr = a; wd = d;
      @(negedge clk);
      we = 1'b0;
      if (a != 5'd0) model[a] = d;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; we = 1'b0; creq = 1'b0; wr = 5'd0; wd = 32'd0; rr1 = 5'd3; rr2 = 5'd0;
      #12;
      checks++;
      if (busy !== 1'b1 || drop !== 1'b0 || tap !== 32'd0) begin
         errors++;
         $display("FAIL reset_state: got busy=%b drop=%b tap=%h expected 1/0/0", busy, drop, tap);
      end
      @(negedge clk);
      rst_n = 1'b1;
      count_sweep("post_reset", 31);
      check_all_zero("post_reset");
   endtask

   task automatic test_bypass;
      @(negedge clk);
      rr1 = 5'd31; we = 1'b1; wr = 5'd31; wd = 32'hDEADBEEF;
      #1;
      checks++;
      if (rd1 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL bypass_same_cycle: got %h expected deadbeef", rd1);
      end
      @(negedge clk);
      we = 1'b0; model[31] = 32'hDEADBEEF;
      #1;
      checks++;
      if (rd1 !== 32'hDEADBEEF || drop !== 1'b0) begin
         errors++;
         $display("FAIL bypass_stored: got %h drop=%b expected deadbeef drop=0", rd1, drop);
      end
   endtask

   task automatic test_x0;
      @(negedge clk);
      rr1 = 5'd0; rr2 = 5'd0; we = 1'b1; wr = 5'd0; wd = 32'h12345678;
      #1;
      checks++;
      if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
         errors++;
         $display("FAIL x0_during: got %h/%h expected 0", rd1, rd2);
      end
      @(negedge clk);
      we = 1'b0;
      #1;
      checks++;
      if (rd1 !== 32'd0 || rd2 !== 32'd0 || drop !== 1'b0) begin
         errors++;
         $display("FAIL x0_after: got %h/%h drop=%b expected 0/0/0", rd1, rd2, drop);
      end
   endtask

   task automatic test_tap;
      @(negedge clk);
      rr2 = 5'd5; we = 1'b1; wr = 5'd5; wd = 32'h41;
      #1;
      checks++;
      if (rd2 !== 32'h41 || tap !== model[5]) begin
         errors++;
         $display("FAIL tap_pre_edge: got rd2=%h tap=%h expected 41/%h", rd2, tap, model[5]);
      end
      @(negedge clk);
      we = 1'b0; model[5] = 32'h41;
      checks++;
      if (tap !== 32'h41) begin
         errors++;
         $display("FAIL tap_post_edge: got %h expected 41", tap);
      end
   endtask

   task automatic test_random;
      for (int n = 0; n < 80; n++) begin
         @(negedge clk);
         checks++;
         if (tap !== model[5]) begin
            errors++;
            $display("FAIL rand_tap it%0d: got %h expected %h", n, tap, model[5]);
         end
         we = 1'($urandom_range(0, 1));
         wr = ($urandom_range(0, 3) == 0) ? 5'd5 : 5'($urandom);
         wd = $urandom;
         rr1 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom);
         rr2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom);
         #1;
         checks++;
         if (rd1 !== exp_read(rr1) || rd2 !== exp_read(rr2) || drop !== 1'b0) begin
            errors++;
            $display("FAIL rand_read it%0d: got %h/%h drop=%b expected %h/%h drop=0",
                     n, rd1, rd2, drop, exp_read(rr1), exp_read(rr2));
         end
         @(posedge clk);
         if (we && wr != 5'd0) model[wr] = wd;
      end
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic test_clear;
      int cnt = 0;
      for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i));
      check_all_zero_negated: begin
         rr1 = 5'd17;
         #1;
         checks++;
         if (rd1 !== 32'd17) begin
            errors++;
            $display("FAIL fill_readback: got %h expected 11", rd1);
         end
      end
      @(negedge clk);
      creq = 1'b1;
      @(negedge clk);
      creq = 1'b0;
      rr1 = 5'd7;
      while (busy === 1'b1 && cnt < 200) begin
         cnt++;
         if (cnt == 6) begin
            checks++;
            if (drop !== 1'b1) begin
               errors++;
               $display("FAIL clear_write_drop: got %b expected 1", drop);
            end
         end
         if (cnt == 7) begin
            checks++;
            if (drop !== 1'b0) begin
               errors++;
               $display("FAIL clear_drop_pulse_end: got %b expected 0", drop);
            end
         end
         we = (cnt == 5);
         wr = 5'd7;
         wd = 32'hCAFE0007;
         creq = (cnt == 10);
         #1;
         checks++;
         if (rd1 !== 32'd0) begin
            errors++;
            $display("FAIL clear_read_sweep c%0d: got %h expected 0", cnt, rd1);
         end
         @(negedge clk);
      end
      we = 1'b0; creq = 1'b0;
      checks++;
      if (cnt != 31) begin
         errors++;
         $display("FAIL clear_busy_cycles: got %0d expected 31", cnt);
      end
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      check_all_zero("clear");
      checks++;
      if (tap !== 32'd0 || drop !== 1'b0) begin
         errors++;
         $display("FAIL clear_tap: got tap=%h drop=%b expected 0/0", tap, drop);
      end
   endtask

   task automatic test_reset_mid_sweep;
      do_write(5'd20, 32'hA5A5A5A5);
      do_write(5'd31, 32'h5A5A5A5A);
      do_write(5'd5, 32'h00000099);
      @(negedge clk);
      creq = 1'b1;
      @(negedge clk);
      creq = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b1 || drop !== 1'b0 || tap !== 32'd0) begin
         errors++;
         $display("FAIL midsweep_reset: got busy=%b drop=%b tap=%h expected 1/0/0", busy, drop, tap);
      end
      @(negedge clk);
      rst_n = 1'b1;
      count_sweep("midsweep", 31);
      check_all_zero("midsweep");
   endtask

   task automatic test_param64;
      int cnt = 0;
      logic [63:0] v = {$urandom, $urandom};
      rst64_n = 1'b0; we_64 = 1'b0; creq_64 = 1'b0; wr_64 = 4'd0; wd_64 = 64'd0;
      rr1_64 = 4'd0; rr2_64 = 4'd0;
      @(negedge clk);
      rst64_n = 1'b1;
      while (busy_64 === 1'b1 && cnt < 200) begin
         cnt++;
         @(negedge clk);
      end
      checks++;
      if (cnt != 15) begin
         errors++;
         $display("FAIL p64_busy_cycles: got %0d expected 15", cnt);
      end
      for (int i = 0; i < 16; i++) begin
         rr1_64 = 4'(i);
         #1;
         checks++;
         if (rd1_64 !== 64'd0) begin
            errors++;
            $display("FAIL p64_zero r%0d: got %h expected 0", i, rd1_64);
         end
      end
      @(negedge clk);
      rr1_64 = 4'd15; we_64 = 1'b1; wr_64 = 4'd15; wd_64 = 64'hDEADBEEF_CAFEF00D;
      #1;
      checks++;
      if (rd1_64 !== 64'hDEADBEEF_CAFEF00D) begin
         errors++;
         $display("FAIL p64_bypass: got %h expected deadbeefcafef00d", rd1_64);
      end
      @(negedge clk);
      wr_64 = 4'd5; wd_64 = v; rr2_64 = 4'd5;
      #1;
      checks++;
      if (rd1_64 !== 64'hDEADBEEF_CAFEF00D || rd2_64 !== v) begin
         errors++;
         $display("FAIL p64_stored: got %h/%h expected deadbeefcafef00d/%h", rd1_64, rd2_64, v);
      end
      @(negedge clk);
      we_64 = 1'b0;
      checks++;
      if (tap_64 !== v || drop_64 !== 1'b0) begin
         errors++;
         $display("FAIL p64_tap: got %h drop=%b expected %h drop=0", tap_64, drop_64, v);
      end
   endtask

   initial begin
      rst64_n = 1'b0; we_64 = 1'b0; creq_64 = 1'b0; wr_64 = 4'd0; wd_64 = 64'd0;
      rr1_64 = 4'd0; rr2_64 = 4'd0;
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      test_reset();
      test_bypass();
      test_x0();
      test_tap();
      test_random();
      test_clear();
      test_reset_mid_sweep();
      test_param64();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
